// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Round-robin arbiter and access sequencer for one shared 32-bit memory port
// used by four requesters. The winner index drives the select of an external
// 4-to-1 datapath mux, so the winner's address and write data reach memory.
// The block issues the read or write strobe, waits for the memory acknowledge
// and returns a one-cycle completion pulse to the requester. A watchdog aborts
// any access that is never acknowledged.
//
// Handshake: a requester raises req[i] (with write_req[i] giving the access
// type) and holds it until it sees done[i]. The request is consumed at the
// grant edge; later changes to req/write_req do not affect the access. done[i]
// is a single-cycle pulse; error is high in the same cycle when the watchdog
// ended the access instead of mem_ack.
//
// Parameters:
//   TIMEOUT    max ACCESS cycles without mem_ack before abort (0 = no watchdog)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   req        per-requester request
//   write_req  per-requester access type (1 = write), sampled at grant
//   mem_ack    memory completion, sampled only during ACCESS
//   mux_sel    granted requester index (datapath mux select)
//   grant      one-hot grant, zero when no grant is held
//   mem_read   read strobe to memory
//   mem_write  write strobe to memory
//   done       one-cycle completion pulse per requester
//   error      one-cycle watchdog-abort flag, coincident with done
//   busy       high during ACCESS and RESP
//   dbg_state  current FSM state (IDLE=0, ACCESS=1, RESP=2)
//
// All outputs are registered; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] write_req,
    input  logic       mem_ack,
    output logic [1:0] mux_sel,
    output logic [3:0] grant,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] done,
    output logic       error,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic          wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    mux_sel_d;
    logic [3:0]    grant_d;
    logic          mem_read_d, mem_write_d;
    logic [3:0]    done_d;
    logic          error_d, busy_d;

    logic [1:0]    win_idx;
    logic          timeout_hit;

    assign dbg_state = state_q;

    // Watchdog fires on the edge that ends the TIMEOUT-th ACCESS cycle.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Round-robin search starting just after the last winner. Scanning the
    // candidates from farthest to nearest lets the nearest set request win.
    always_comb begin : pick_winner
        logic [1:0] cand;
        cand    = 2'd0;
        win_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            cand = last_q + 2'(i + 1);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        mux_sel_d   = mux_sel;
        grant_d     = grant;
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
        busy_d      = busy;
        done_d      = 4'b0000;
        error_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                grant_d     = 4'b0000;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                busy_d      = 1'b0;
                if (|req) begin
                    state_d     = S_ACCESS;
                    last_d      = win_idx;
                    mux_sel_d   = win_idx;
                    grant_d     = 4'b0001 << win_idx;
                    wr_d        = write_req[win_idx];
                    cnt_d       = '0;
                    mem_read_d  = ~write_req[win_idx];
                    mem_write_d = write_req[win_idx];
                    busy_d      = 1'b1;
                end
            end

            S_ACCESS: begin
                // mem_ack takes priority over a simultaneous timeout.
                if (mem_ack || timeout_hit) begin
                    state_d     = S_RESP;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    done_d      = 4'b0001 << last_q;
                    error_d     = ~mem_ack;
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                    mem_read_d  = ~wr_q;
                    mem_write_d = wr_q;
                end
            end

            S_RESP: begin
                state_d     = S_IDLE;
                grant_d     = 4'b0000;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                busy_d      = 1'b0;
            end

            default: begin
                state_d     = S_IDLE;
                grant_d     = 4'b0000;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            last_q    <= 2'b11;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            mux_sel   <= 2'b00;
            grant     <= 4'b0000;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= 4'b0000;
            error     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            mux_sel   <= mux_sel_d;
            grant     <= grant_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            done      <= done_d;
            error     <= error_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Transaction-level bench for mem_port_arbiter (TIMEOUT=4). The reference
// model is a pending-request mask plus the last winner index; the winner is
// the first pending index found counting up (mod 4) from last+1. Each access
// pushes its expected {error, done} into exp_q, popped at the response cycle.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] write_req;
    logic       mem_ack;
    logic [1:0] mux_sel;
    logic [3:0] grant;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] done;
    logic       error;
    logic       busy;
    logic [1:0] dbg_state;

    int         n_checks = 0;
    int         n_errors = 0;

    logic [3:0] pending;
    int         last_idx;
    int         exp_mux;
    logic [4:0] exp_q[$];

    mem_port_arbiter #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .write_req (write_req),
        .mem_ack   (mem_ack),
        .mux_sel   (mux_sel),
        .grant     (grant),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .done      (done),
        .error     (error),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pick(input logic [3:0] p, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mux_sel"}, mux_sel, 0);
        check_val({tag, "_grant"}, grant, 0);
        check_val({tag, "_mem_read"}, mem_read, 0);
        check_val({tag, "_mem_write"}, mem_write, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_error"}, error, 0);
        check_val({tag, "_busy"}, busy, 0);
    endtask

    // ---------------- drivers ----------------
    // Entry and exit: at a falling edge inside an IDLE cycle.
    task automatic idle_cycles(input int n);
        req = 4'b0000;
        for (int i = 0; i < n; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_val("idle_grant", grant, 0);
            check_val("idle_busy", busy, 0);
            check_val("idle_strobe", {mem_read, mem_write}, 0);
            check_val("idle_mux_sel", mux_sel, exp_mux);
        end
        mem_ack = 1'b0;
    endtask

    // One access for the model's winner. ack_at = ACCESS cycle in which
    // mem_ack is high (0 or > TMO means never). abort_at = ACCESS cycle in
    // which reset is pulsed (0 = no abort).
    task automatic run_xfer(input logic [3:0] wr_bits, input int ack_at, input int abort_at);
        int   w;
        int   end_c;
        int   hi;
        logic wr;
        logic err;

        if (pending == 4'b0000) pending = 4'b0001;
        w         = pick(pending, last_idx);
        req       = pending;
        write_req = wr_bits;
        wr        = wr_bits[w];
        if (ack_at >= 1 && ack_at <= TMO) begin
            end_c = ack_at;
            err   = 1'b0;
        end else begin
            end_c = TMO;
            err   = 1'b1;
        end
        exp_q.push_back({err, 4'(1 << w)});
        hi = 0;

        @(negedge clk);
        check_val("grant", grant, 32'(1 << w));
        check_val("mux_sel", mux_sel, w);
        last_idx = w;
        exp_mux  = w;

        for (int c = 1; c <= end_c; c++) begin
            check_val("mem_read", mem_read, 32'(!wr));
            check_val("mem_write", mem_write, 32'(wr));
            check_val("acc_busy", busy, 1);
            check_val("acc_done", done, 0);
            check_val("acc_grant", grant, 32'(1 << w));
            if (mem_read || mem_write) hi++;
            if (c == abort_at) begin
                #2 reset = 1'b0;
                #1 check_reset_outputs("abort");
                mem_ack  = 1'b0;
                req      = 4'b0000;
                pending  = 4'b0000;
                last_idx = 3;
                exp_mux  = 0;
                void'(exp_q.pop_back());
                @(negedge clk);
                check_reset_outputs("abort_hold");
                reset = 1'b1;
                return;
            end
            mem_ack   = (c == ack_at);
            // Post-grant changes must be ignored, including a dropped request.
            req       = 4'($urandom_range(0, 15));
            write_req = 4'($urandom_range(0, 15));
            @(negedge clk);
        end

        // RESP cycle
        check_val("strobe_len", hi, end_c);
        check_val("done_err", {error, done}, exp_q.pop_front());
        check_val("resp_strobe", {mem_read, mem_write}, 0);
        check_val("resp_grant", grant, 32'(1 << w));
        check_val("resp_mux_sel", mux_sel, w);
        check_val("resp_busy", busy, 1);
        pending[w] = 1'b0;
        req        = pending;
        write_req  = 4'($urandom_range(0, 15));
        mem_ack    = 1'($urandom_range(0, 1));

        // IDLE cycle
        @(negedge clk);
        check_val("post_grant", grant, 0);
        check_val("post_mux_sel", mux_sel, w);
        check_val("post_busy", busy, 0);
        check_val("post_done_err", {error, done}, 0);
        check_val("post_strobe", {mem_read, mem_write}, 0);
        mem_ack = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b0;
        req       = 4'b0000;
        write_req = 4'b0000;
        mem_ack   = 1'b0;
        pending   = 4'b0000;
        last_idx  = 3;
        exp_mux   = 0;

        #3 check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(2);

        // single read, ack in third ACCESS cycle
        pending = 4'b0100;
        run_xfer(4'b0000, 3, 0);

        // fairness: two full rounds, then 3 ahead of 0
        pending = 4'b1111;
        repeat (4) run_xfer(4'($urandom_range(0, 15)), 1, 0);
        pending = 4'b1111;
        repeat (4) run_xfer(4'($urandom_range(0, 15)), 1, 0);
        pending = 4'b0001;
        run_xfer(4'b0000, 1, 0);
        pending = 4'b1001;
        run_xfer(4'b0000, 1, 0);
        run_xfer(4'b0000, 1, 0);

        // write path with write_req toggling mid-access
        pending = 4'b0010;
        run_xfer(4'b0010, 3, 0);

        // watchdog: never acked, then acked in the last allowed cycle
        pending = 4'b0001;
        run_xfer(4'b0000, 0, 0);
        pending = 4'b0001;
        run_xfer(4'b0000, TMO, 0);

        // reset in the middle of an access, then requester 3 alone
        pending = 4'b0100;
        run_xfer(4'b0100, 0, 2);
        pending = 4'b1000;
        run_xfer(4'b0000, 1, 0);

        // request withdrawn right after grant
        pending = 4'b0001;
        run_xfer(4'b0000, 2, 0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
            pending = pending | 4'($urandom_range(0, 15));
            if (pending == 4'b0000) pending = 4'(1 << $urandom_range(0, 3));
            run_xfer(4'($urandom_range(0, 15)), int'($urandom_range(0, 6)), 0);
        end

        check_val("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and access sequencer for one shared 32-bit memory port used by four requesters. It drives the 2-bit select of the 4-to-1 datapath multiplexer, so the winner's address and write data reach the memory. It also issues the memory read or write strobe and waits for the memory acknowledge. Each requester receives a one-cycle completion pulse, and a watchdog aborts any access that is never acknowledged.

## Interface
- TIMEOUT, 16: maximum number of ACCESS cycles without MEM_ACK before the access is aborted; 0 disables the watchdog.
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  reset, asynchronous, active-low.
- REQ  input  4  per-requester request; bit i belongs to requester i.
- WRITE_REQ  input  4  per-requester access type; 1 = write, 0 = read; sampled only at grant.
- MEM_ACK  input  1  memory completion; sampled only in ACCESS.
- MUX_SEL  output  2  index of the granted requester; drives the 4-to-1 datapath mux select.
- GRANT  output  4  one-hot grant; all zero when no grant is held.
- MEM_READ  output  1  read strobe to memory.
- MEM_WRITE  output  1  write strobe to memory.
- DONE  output  4  one-cycle completion pulse to requester i.
- ERROR  output  1  one-cycle pulse, coincident with DONE, when the watchdog aborted the access.
- BUSY  output  1  high in ACCESS and RESP.

## Operation
- State register: IDLE, ACCESS, RESP. Supporting registers:
  - LAST, 2 bits: last granted index.
  - WR_LATCH: access type captured at grant.
  - CNT: watchdog counter, width $clog2(TIMEOUT+1), minimum 1 bit.
- IDLE:
  - If REQ is nonzero, search starts at index (LAST+1) mod 4 and increments mod 4. The first index with REQ set wins.
  - On that edge: MUX_SEL and LAST take the winner index; GRANT[winner]=1; WR_LATCH=WRITE_REQ[winner]; CNT=0; next state is ACCESS.
  - If REQ is zero, remain in IDLE.
- ACCESS:
  - MEM_READ = ~WR_LATCH and MEM_WRITE = WR_LATCH. Both are registered outputs, held every cycle in the state.
  - If MEM_ACK=1 at an edge, go to RESP with ERROR=0.
  - Otherwise, if TIMEOUT≠0 and CNT==TIMEOUT-1, go to RESP with ERROR=1.
  - Otherwise CNT increments and the state stays ACCESS.
  - MEM_ACK and timeout at the same edge: MEM_ACK wins, so ERROR=0.
- RESP, exactly one cycle:
  - DONE[LAST]=1; ERROR as decided on entry.
  - MEM_READ=MEM_WRITE=0; MUX_SEL and GRANT held.
  - Next state is IDLE, where GRANT clears to 0 and MUX_SEL holds its value.
- Changes to REQ and WRITE_REQ after grant are ignored. A requester dropping REQ mid-access does not cancel the access; DONE still pulses.
- MEM_ACK outside ACCESS is ignored.
- Requesters hold REQ until they see DONE. A REQ still high in the IDLE cycle after DONE is re-arbitrated normally; rotation prevents starvation.

## Timing
- Reset values, applied immediately on RESET=0 and independent of CLK:
  - State = IDLE, LAST = 2'b11 (requester 0 has first priority).
  - MUX_SEL = 2'b00, GRANT = 4'b0000.
  - MEM_READ = MEM_WRITE = 0, DONE = 4'b0000, ERROR = 0, BUSY = 0, CNT = 0.
- Reset during ACCESS or RESP aborts the access. No DONE is issued for it.
- Grant latency: REQ sampled high at edge k puts GRANT, MUX_SEL, the strobe and BUSY high after edge k.
- Memory latency: MEM_ACK sampled high at edge k+n (n≥1) drops the strobe after edge k+n. DONE is high for the cycle between edges k+n and k+n+1. The next grant can occur at edge k+n+2.
- Minimum access (ACK in the first ACCESS cycle) occupies 3 cycles per transfer: ACCESS, RESP, IDLE.
- Watchdog with TIMEOUT=T: the strobe is held for exactly T cycles, then RESP follows with ERROR=1.
- All outputs are registered. No combinational path exists from any input to any output.

## Test plan
- Single read: REQ=4'b0100, WRITE_REQ=0, MEM_ACK high in the 3rd ACCESS cycle -> MUX_SEL=2, GRANT=4'b0100, MEM_READ high 3 cycles, DONE=4'b0100 for one cycle, ERROR=0.
- Fairness: REQ=4'b1111 held, each requester dropping its bit after its DONE, ACK after 1 cycle -> grant order 0,1,2,3. A second round with all four re-asserted gives 0,1,2,3 again; REQ=4'b1001 right after granting 0 gives 3 before 0.
- Write path: REQ=4'b0010, WRITE_REQ=4'b0010, toggle WRITE_REQ mid-access -> MEM_WRITE high throughout the access, MEM_READ never high.
- Watchdog: TIMEOUT=4, REQ=4'b0001, MEM_ACK never -> MEM_READ high exactly 4 cycles, then DONE=4'b0001 and ERROR=1 together. Repeat with MEM_ACK on the 4th cycle -> ERROR=0.
- Reset mid-access: assert RESET=0 between edges during ACCESS -> all outputs reach their reset values before the next edge. After release, REQ=4'b1000 alone is granted with MUX_SEL=3.
- Request withdrawal: REQ=4'b0001 dropped the cycle after grant, with ACK 2 cycles later -> the access completes and DONE=4'b0001 still pulses.
